// File: rtl/cdr_phase_ctrl.sv
// Bang-bang CDR phase controller: votes from an early/late phase detector are
// integrated into a saturating accumulator that steps a circular interpolator code.
module cdr_phase_ctrl #(
  parameter int CODE_W   = 6,
  parameter int ACC_W    = 8,
  parameter int THR_ACQ  = 4,
  parameter int THR_TRK  = 16,
  parameter int WIN_W    = 8,
  parameter int LOCK_MAX = 2,
  parameter int NT_MAX   = 200
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_t,
  input  logic              i_e,
  input  logic              i_load,
  input  logic [CODE_W-1:0] i_code_init,
  output logic [CODE_W-1:0] o_ph_code,
  output logic              o_ph_up,
  output logic              o_ph_dn,
  output logic              o_locked,
  output logic              o_los
);

  localparam int SC_W = $clog2(LOCK_MAX + 2);
  localparam int NT_W = $clog2(NT_MAX + 1);

  localparam logic signed [ACC_W:0] ACC_HI = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] ACC_LO = $signed({2'b11, {(ACC_W-1){1'b0}}});
  localparam logic signed [ACC_W:0] THR_A  = (ACC_W+1)'(THR_ACQ);
  localparam logic signed [ACC_W:0] THR_T  = (ACC_W+1)'(THR_TRK);
  localparam logic [SC_W-1:0]       SC_LIM = SC_W'(LOCK_MAX);
  localparam logic [SC_W-1:0]       SC_SAT = SC_W'(LOCK_MAX + 1);
  localparam logic [NT_W-1:0]       NT_SAT = NT_W'(NT_MAX);
  localparam logic [WIN_W-1:0]      WIN_END = {WIN_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_TRACK
  } state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CODE_W-1:0]        r_code;
  logic                     r_ph_up;
  logic                     r_ph_dn;
  logic                     r_locked;
  logic                     r_los;
  logic                     r_los_q;
  logic [WIN_W-1:0]         r_win;
  logic [SC_W-1:0]          r_steps;
  logic [NT_W-1:0]          r_nt;

  logic signed [ACC_W:0]    w_vote;
  logic signed [ACC_W:0]    w_acc_ext;
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W:0]    w_sum_sat;
  logic signed [ACC_W:0]    w_thr;
  logic signed [ACC_W:0]    w_thr_neg;
  logic                     w_step_ok;
  logic                     w_up;
  logic                     w_dn;
  logic [SC_W-1:0]          w_steps_inc;
  logic [NT_W-1:0]          w_nt_next;
  logic                     w_los_rise;
  logic                     w_win_end;

  always_comb begin
    w_vote = '0;
    if (i_en && i_t) begin
      w_vote = i_e ? '1 : (ACC_W+1)'(1);
    end
  end

  assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
  assign w_sum     = w_acc_ext + w_vote;

  always_comb begin
    w_sum_sat = w_sum;
    if (w_sum > ACC_HI) begin
      w_sum_sat = ACC_HI;
    end else if (w_sum < ACC_LO) begin
      w_sum_sat = ACC_LO;
    end
  end

  assign w_thr     = (r_state == S_TRACK) ? THR_T : THR_A;
  assign w_thr_neg = -w_thr;

  // LOAD wins over a threshold crossing; IDLE only integrates, never steps.
  assign w_step_ok = i_en && (r_state != S_IDLE) && !i_load;
  assign w_up      = w_step_ok && (w_sum_sat >= w_thr);
  assign w_dn      = w_step_ok && (w_sum_sat <= w_thr_neg);

  assign w_steps_inc = ((w_up || w_dn) && (r_steps != SC_SAT)) ? r_steps + SC_W'(1) : r_steps;

  always_comb begin
    w_nt_next = r_nt;
    if (i_t) begin
      w_nt_next = '0;
    end else if (r_nt != NT_SAT) begin
      w_nt_next = r_nt + NT_W'(1);
    end
  end

  assign w_los_rise = r_los && !r_los_q;
  assign w_win_end  = (r_win == WIN_END);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_code   <= '0;
      r_ph_up  <= 1'b0;
      r_ph_dn  <= 1'b0;
      r_locked <= 1'b0;
      r_los    <= 1'b0;
      r_los_q  <= 1'b0;
      r_win    <= '0;
      r_steps  <= '0;
      r_nt     <= '0;
    end else begin
      r_los_q <= r_los;
      r_ph_up <= w_up;
      r_ph_dn <= w_dn;

      if (i_load) begin
        r_code <= i_code_init;
      end else if (w_up) begin
        r_code <= r_code + CODE_W'(1);
      end else if (w_dn) begin
        r_code <= r_code - CODE_W'(1);
      end

      // The no-transition counter only advances with the loop enabled.
      if (i_en) begin
        r_nt  <= w_nt_next;
        r_los <= (w_nt_next == NT_SAT);
      end

      if (!i_en) begin
        r_state  <= S_IDLE;
        r_acc    <= '0;
        r_win    <= '0;
        r_steps  <= '0;
        r_locked <= 1'b0;
      end else begin
        r_acc <= (i_load || w_up || w_dn) ? '0 : w_sum_sat[ACC_W-1:0];
        if (w_los_rise || r_state == S_IDLE) begin
          r_state  <= S_ACQ;
          r_win    <= '0;
          r_steps  <= '0;
          r_locked <= 1'b0;
        end else if (w_win_end) begin
          r_win   <= '0;
          r_steps <= '0;
          case (r_state)
            S_ACQ: begin
              if (w_steps_inc <= SC_LIM) begin
                r_state  <= S_TRACK;
                r_locked <= 1'b1;
              end
            end
            S_TRACK: begin
              if (w_steps_inc > SC_LIM) begin
                r_state  <= S_ACQ;
                r_locked <= 1'b0;
              end
            end
            default: begin
              r_state  <= S_IDLE;
              r_locked <= 1'b0;
            end
          endcase
        end else begin
          r_win   <= r_win + WIN_W'(1);
          r_steps <= w_steps_inc;
        end
      end
    end
  end

  assign o_ph_code = r_code;
  assign o_ph_up   = r_ph_up;
  assign o_ph_dn   = r_ph_dn;
  assign o_locked  = r_locked;
  assign o_los     = r_los;

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Randomized and directed bench for cdr_phase_ctrl against a cycle-level
// behavioural model of the loop rules.
module tb_cdr_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       t;
  logic       e;
  logic       load;
  logic [5:0] code_init;
  logic [5:0] ph_code;
  logic       ph_up;
  logic       ph_dn;
  logic       locked;
  logic       los;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state (plain integers).
  int m_code, m_acc, m_win, m_steps, m_nt, m_state;
  bit m_up, m_dn, m_los, m_los_prev;
  int step_count;

  cdr_phase_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_t        (t),
    .i_e        (e),
    .i_load     (load),
    .i_code_init(code_init),
    .o_ph_code  (ph_code),
    .o_ph_up    (ph_up),
    .o_ph_dn    (ph_dn),
    .o_locked   (locked),
    .o_los      (los)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_code = 0; m_acc = 0; m_win = 0; m_steps = 0; m_nt = 0; m_state = 0;
    m_up = 0; m_dn = 0; m_los = 0; m_los_prev = 0;
  endtask

  // States: 0 = idle, 1 = acquire, 2 = track.
  task automatic model_update(input bit v_en, input bit v_t, input bit v_e,
                              input bit v_ld, input int v_init);
    int  vote, s, thr, st;
    bit  up, dn, new_los, rise;
    vote = (v_en && v_t) ? (v_e ? -1 : 1) : 0;
    s = m_acc + vote;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    thr = (m_state == 2) ? 16 : 4;
    up = v_en && (m_state != 0) && !v_ld && (s >= thr);
    dn = v_en && (m_state != 0) && !v_ld && (s <= -thr);
    if (v_ld) m_code = v_init;
    else if (up) m_code = (m_code + 1) % 64;
    else if (dn) m_code = (m_code + 63) % 64;
    m_up = up;
    m_dn = dn;
    if (v_en) m_nt = v_t ? 0 : ((m_nt < 200) ? m_nt + 1 : 200);
    new_los = (m_nt == 200);
    rise = m_los && !m_los_prev;
    if (!v_en) begin
      m_state = 0; m_acc = 0; m_win = 0; m_steps = 0;
    end else begin
      m_acc = (v_ld || up || dn) ? 0 : s;
      if (rise || m_state == 0) begin
        m_state = 1; m_win = 0; m_steps = 0;
      end else begin
        st = m_steps + ((up || dn) ? 1 : 0);
        if (st > 3) st = 3;
        if (m_win == 255) begin
          if (m_state == 1 && st <= 2) m_state = 2;
          else if (m_state == 2 && st > 2) m_state = 1;
          m_win = 0;
          m_steps = 0;
        end else begin
          m_win++;
          m_steps = st;
        end
      end
    end
    m_los_prev = m_los;
    m_los = new_los;
  endtask

  task automatic compare_all();
    check("code", ph_code, m_code);
    check("up", ph_up, m_up);
    check("dn", ph_dn, m_dn);
    check("locked", locked, (m_state == 2));
    check("los", los, m_los);
  endtask

  task automatic cycle(input bit v_en, input bit v_t, input bit v_e,
                       input bit v_ld, input int v_init);
    en = v_en; t = v_t; e = v_e; load = v_ld; code_init = 6'(v_init);
    @(posedge clk);
    model_update(v_en, v_t, v_e, v_ld, v_init);
    @(negedge clk);
    compare_all();
    if (ph_up || ph_dn) step_count++;
  endtask

  task automatic lock_up();
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 257; i++) cycle(1, 1, i[0], 0, 0);
  endtask

  initial begin
    rst = 1'b1; en = 0; t = 0; e = 0; load = 0; code_init = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_code", ph_code, 0);
    check("rst_up", ph_up, 0);
    check("rst_dn", ph_dn, 0);
    check("rst_locked", locked, 0);
    check("rst_los", los, 0);
    rst = 1'b0;
    $display("scenario reset done");

    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    check("first_up", ph_up, 1);
    check("first_code", ph_code, 1);
    $display("scenario first step code=%0d", ph_code);

    cycle(1, 0, 0, 1, 63);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    check("wrap_up_code", ph_code, 0);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
    check("wrap_dn_code", ph_code, 63);
    check("wrap_dn_pulse", ph_dn, 1);
    $display("scenario wrap code=%0d", ph_code);

    step_count = 0;
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) cycle(1, 1, i[0], 0, 0);
    check("alt_steps", step_count, 0);
    check("alt_locked", locked, 1);
    step_count = 0;
    for (int i = 0; i < 256; i++) cycle(1, 1, 0, 0, 0);
    check("late_steps", step_count, 16);
    check("late_locked", locked, 0);
    $display("scenario lock/unlock steps=%0d", step_count);

    lock_up();
    check("pre_los_locked", locked, 1);
    for (int i = 0; i < 199; i++) cycle(1, 0, 0, 0, 0);
    check("los_199", los, 0);
    cycle(1, 0, 0, 0, 0);
    check("los_200", los, 1);
    check("los_locked_same", locked, 1);
    cycle(1, 0, 0, 0, 0);
    check("los_unlock", locked, 0);
    cycle(1, 1, 0, 0, 0);
    check("los_clear", los, 0);
    $display("scenario loss-of-signal");

    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 21);
    check("ld_cross_code", ph_code, 21);
    check("ld_cross_up", ph_up, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
    check("ld_acc_clear", ph_up, 0);
    cycle(1, 1, 0, 0, 0);
    check("ld_acc_step", ph_up, 1);
    $display("scenario load on crossing code=%0d", ph_code);

    for (int seg = 0; seg < 30; seg++) begin
      int p_early = $urandom_range(0, 100);
      for (int i = 0; i < 50; i++) begin
        bit r_en = ($urandom_range(0, 99) < 95);
        bit r_t  = ($urandom_range(0, 99) < 70);
        bit r_e  = ($urandom_range(0, 99) < p_early);
        bit r_ld = ($urandom_range(0, 99) < 1);
        cycle(r_en, r_t, r_e, r_ld, int'($urandom_range(0, 63)));
      end
      $display("scenario random segment %0d early%%=%0d code=%0d", seg, p_early, ph_code);
    end

    lock_up();
    cycle(1, 1, 0, 1, 37);
    check("pre_rst_code", ph_code, 37);
    check("pre_rst_locked", locked, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_code", ph_code, 0);
    check("arst_up", ph_up, 0);
    check("arst_dn", ph_dn, 0);
    check("arst_locked", locked, 0);
    check("arst_los", los, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0);
    $display("scenario async reset code=%0d", ph_code);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdr_phase_ctrl.md
CDR_PHASE_CTRL -- requirements
Module: cdr_phase_ctrl

Interface
REQ-001 Parameter CODE_W, default 6: phase-interpolator code width; the code is circular.
REQ-002 Parameter ACC_W, default 8: width of the signed vote accumulator.
REQ-003 Parameter THR_ACQ, default 4: step threshold while acquiring.
REQ-004 Parameter THR_TRK, default 16: step threshold while tracking.
REQ-005 Parameter WIN_W, default 8: lock window length is 2^WIN_W cycles.
REQ-006 Parameter LOCK_MAX, default 2: maximum code steps per window while locked.
REQ-007 Parameter NT_MAX, default 200: number of cycles without a transition before loss-of-signal.
REQ-008 CLK  in  1  sole clock; all state SHALL update on the rising edge.
REQ-009 RST  in  1  asynchronous, active-high reset.
REQ-010 EN  in  1  loop enable; 0 freezes the loop.
REQ-011 T  in  1  bang-bang phase detector transition flag; 1 = data transition seen this cycle.
REQ-012 E  in  1  phase detector early flag; valid only when T=1; 1 = clock early, 0 = clock late.
REQ-013 LOAD  in  1  synchronous load of CODE_INIT into PH_CODE.
REQ-014 CODE_INIT  in  CODE_W  code value loaded by LOAD.
REQ-015 PH_CODE  out  CODE_W  registered phase-interpolator code.
REQ-016 PH_UP  out  1  one-cycle pulse when PH_CODE increments.
REQ-017 PH_DN  out  1  one-cycle pulse when PH_CODE decrements.
REQ-018 LOCKED  out  1  1 while the FSM is in TRACK.
REQ-019 LOS  out  1  loss-of-signal flag.

Function
REQ-020 Each cycle, vote SHALL be derived from the inputs: with EN=1 and T=1, E=1 gives vote = -1 and E=0 gives vote = +1; otherwise vote = 0.
REQ-021 The accumulator update SHALL be ACC <= ACC + vote, saturating at the signed ACC_W limits.
REQ-022 THR SHALL be THR_ACQ in state ACQ and THR_TRK in state TRACK.
REQ-023 If ACC+vote >= THR, then on the same edge PH_CODE <= PH_CODE+1 mod 2^CODE_W, PH_UP SHALL be 1 for one cycle, and ACC SHALL be cleared to 0.
REQ-024 If ACC+vote <= -THR, then on the same edge PH_CODE <= PH_CODE-1 mod 2^CODE_W, PH_DN SHALL be 1 for one cycle, and ACC SHALL be cleared to 0.
REQ-025 PH_CODE SHALL wrap around: 2^CODE_W-1 followed by an up step gives 0, and 0 followed by a down step gives 2^CODE_W-1.
REQ-026 PH_UP and PH_DN SHALL never be 1 in the same cycle.
REQ-027 LOAD=1 SHALL set PH_CODE <= CODE_INIT and clear ACC; LOAD SHALL take priority over a step, and that cycle SHALL produce no PH_UP or PH_DN pulse.
REQ-028 FSM states: IDLE, ACQ, TRACK.
REQ-029 FSM transitions: IDLE goes to ACQ when EN=1; any state goes to IDLE when EN=0, which also clears ACC, the window counter and the step counter.
REQ-030 In ACQ and TRACK, the window counter SHALL count 0 to 2^WIN_W-1 and then wrap.
REQ-031 In ACQ and TRACK, the step counter SHALL count PH_UP/PH_DN events and saturate at LOCK_MAX+1.
REQ-032 At the window end (counter = 2^WIN_W-1), a step occurring in that same cycle SHALL be counted in the ending window.
REQ-033 At the window end, ACQ SHALL go to TRACK if steps <= LOCK_MAX, and TRACK SHALL go to ACQ if steps > LOCK_MAX.
REQ-034 At the window end, the step counter SHALL be cleared.
REQ-035 A no-transition counter SHALL increment each EN=1 cycle with T=0, clear on T=1, and saturate at NT_MAX.
REQ-036 LOS SHALL be 1 while the no-transition counter equals NT_MAX.
REQ-037 LOS rising SHALL force ACQ on the next edge and restart the window.
REQ-038 The no-transition counter SHALL hold while EN=0.
REQ-039 In IDLE, PH_CODE SHALL hold its value except on LOAD.
REQ-040 Every output SHALL be driven directly from a register.

Reset
REQ-041 RST=1 SHALL immediately set PH_CODE=0, PH_UP=0, PH_DN=0, LOCKED=0, LOS=0, ACC=0, all counters=0, FSM=IDLE.
REQ-042 Reset asserted mid-step or mid-window SHALL discard the pending step; after release the first update SHALL occur on the first rising CLK edge with RST=0.

Verification
REQ-043 Reset release, EN=1, then 4 cycles of T=1,E=0 -> PH_UP on the 4th edge, PH_CODE 0->1, ACC=0.
REQ-044 LOAD with CODE_INIT=63, then 4 late votes -> PH_CODE=0 (wrap-around); with CODE_INIT=0, 4 early votes -> PH_CODE=63 and PH_DN pulse.
REQ-045 Alternating E=0/E=1 with T=1 for 256 cycles -> no steps, LOCKED=1 after the first window end; afterwards a late vote every cycle for 256 cycles -> 16 steps at THR_TRK, LOCKED=0 at the window end.
REQ-046 EN=1, T=0 for 200 cycles while in TRACK -> LOS=1 on the 200th cycle and LOCKED=0 on the next edge; one T=1 cycle -> LOS=0.
REQ-047 LOAD asserted on the same cycle as a threshold crossing -> PH_CODE=CODE_INIT, no pulse, ACC=0.
REQ-048 RST pulsed asynchronously between edges while in TRACK with PH_CODE=37 -> all outputs 0 immediately, FSM=IDLE.
